fetch_sequencer: RTL and testbench

//  Top-level instruction sequencer for the simple CPU. Drives PC/IR/memory-address control to fetch

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_sequencer_counter.sv | 24 ++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state codes, memory commands,
// the HALT opcode and counter widths.
package fetch_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_IDLE = 4'd1,
    ST_IF1  = 4'd2,
    ST_IF2  = 4'd3,
    ST_UPD  = 4'd4,
    ST_DISP = 4'd5,
    ST_ACK  = 4'd6,
    ST_EXEC = 4'd7,
    ST_HALT = 4'd8,
    ST_ERR  = 4'd9
  } state_t;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int LAT_W = 3;
  localparam int TMO_W = 16;

endpackage

// File: rtl/fetch_sequencer_counter.sv
// Loadable up/down counter shared by the memory-latency and execute-timeout paths.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + W'(1) : count - W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks PC/IR/memory control through a fetch,
// hands off to the execute controller over s/w, and traps HALT and execute hangs.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          MEM_LAT      = 1,
  parameter logic [15:0] EXEC_TIMEOUT = 16'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       w,
  input  logic [2:0] ir_opcode,
  input  logic [1:0] exec_mem_cmd,
  output logic       s,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       load_ir,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       error
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = EXEC_TIMEOUT - 16'd1;

  state_t             state;
  state_t             state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               lat_load;
  logic               tmo_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Latency count is reloaded on every entry to IF1, including the EXEC -> IF1 loop.
  assign lat_load = (state_nxt == ST_IF1) && (state != ST_IF1);

  seq_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_INIT),
    .en       (state == ST_IF1),
    .up       (1'b0),
    .count    (lat_cnt)
  );

  // ACK is only reachable from DISP, so clearing in DISP zeroes the count on ACK entry.
  seq_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_DISP),
    .load_val ('0),
    .en       ((state == ST_ACK) || (state == ST_EXEC)),
    .up       (1'b1),
    .count    (tmo_cnt)
  );

  assign tmo_hit = (EXEC_TIMEOUT != 16'd0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    s         = 1'b0;
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    load_ir   = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MNONE;
    halted    = 1'b0;
    error     = 1'b0;
    case (state)
      ST_RST: begin
        reset_pc  = 1'b1;
        load_pc   = 1'b1;
        state_nxt = run ? ST_IF1 : ST_RST;
      end
      ST_IDLE: state_nxt = run ? ST_IF1 : ST_IDLE;
      ST_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MREAD;
        if (lat_cnt == '0) state_nxt = ST_IF2;
      end
      ST_IF2: begin
        addr_sel  = 1'b1;
        mem_cmd   = MREAD;
        load_ir   = 1'b1;
        state_nxt = ST_UPD;
      end
      ST_UPD: begin
        if (ir_opcode == OP_HALT) begin
          state_nxt = ST_HALT;
        end else begin
          load_pc   = 1'b1;
          state_nxt = ST_DISP;
        end
      end
      ST_DISP: begin
        s         = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        s = 1'b1;
        if (!w)          state_nxt = ST_EXEC;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_EXEC: begin
        mem_cmd = exec_mem_cmd;
        if (w)            state_nxt = run ? ST_IF1 : ST_IDLE;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  error  = 1'b1;
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two configurations (MEM_LAT=1/EXEC_TIMEOUT=255 and
// MEM_LAT=3/EXEC_TIMEOUT=8) against a timeline-based reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] run;
  logic [1:0] w;
  logic [2:0] op  [2];
  logic [1:0] emc [2];
  logic [1:0] s, reset_pc, load_pc, load_ir, addr_sel, halted, error;
  logic [1:0] mem_cmd [2];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_LAT(1), .EXEC_TIMEOUT(16'd255)) dut_a (
    .clk(clk), .reset(reset), .run(run[0]), .w(w[0]), .ir_opcode(op[0]),
    .exec_mem_cmd(emc[0]), .s(s[0]), .reset_pc(reset_pc[0]), .load_pc(load_pc[0]),
    .load_ir(load_ir[0]), .addr_sel(addr_sel[0]), .mem_cmd(mem_cmd[0]),
    .halted(halted[0]), .error(error[0])
  );

  fetch_sequencer #(.MEM_LAT(3), .EXEC_TIMEOUT(16'd8)) dut_b (
    .clk(clk), .reset(reset), .run(run[1]), .w(w[1]), .ir_opcode(op[1]),
    .exec_mem_cmd(emc[1]), .s(s[1]), .reset_pc(reset_pc[1]), .load_pc(load_pc[1]),
    .load_ir(load_ir[1]), .addr_sel(addr_sel[1]), .mem_cmd(mem_cmd[1]),
    .halted(halted[1]), .error(error[1])
  );

  // Reference model: fetch is a timeline indexed by cycles since fetch start;
  // the handshake is a count of cycles spent waiting on the execute controller.
  typedef enum {P_RESET, P_IDLE, P_FETCH, P_ACK, P_EXEC, P_HALT, P_ERR} phase_t;
  phase_t ph [2];
  int     age [2];
  int     waited [2];

  function automatic int ml(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int tmo(input int i);
    return (i == 0) ? 255 : 8;
  endfunction

  function automatic bit timed_out(input int i);
    return (tmo(i) != 0) && (waited[i] == tmo(i) - 1);
  endfunction

  task automatic model_step(input int i);
    if (!reset) begin
      ph[i] = P_RESET;
      return;
    end
    case (ph[i])
      P_RESET, P_IDLE: if (run[i]) begin ph[i] = P_FETCH; age[i] = 0; end
      P_FETCH: begin
        if (age[i] == ml(i) + 1 && op[i] == 3'b111) ph[i] = P_HALT;
        else if (age[i] == ml(i) + 2) begin ph[i] = P_ACK; waited[i] = 0; end
        else age[i]++;
      end
      P_ACK: begin
        if (!w[i]) begin ph[i] = P_EXEC; waited[i]++; end
        else if (timed_out(i)) ph[i] = P_ERR;
        else waited[i]++;
      end
      P_EXEC: begin
        if (w[i]) begin ph[i] = run[i] ? P_FETCH : P_IDLE; age[i] = 0; end
        else if (timed_out(i)) ph[i] = P_ERR;
        else waited[i]++;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input int i, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, i, obs, exp);
  endtask

  task automatic check_all();
    logic e_s, e_rpc, e_lpc, e_lir, e_as, e_halt, e_err;
    logic [1:0] e_mc;
    for (int i = 0; i < 2; i++) begin
      {e_s, e_rpc, e_lpc, e_lir, e_as, e_halt, e_err} = '0;
      e_mc = 2'b00;
      case (ph[i])
        P_RESET: begin e_rpc = 1'b1; e_lpc = 1'b1; end
        P_FETCH: begin
          if (age[i] < ml(i)) begin e_as = 1'b1; e_mc = 2'b01; end
          else if (age[i] == ml(i)) begin e_as = 1'b1; e_mc = 2'b01; e_lir = 1'b1; end
          else if (age[i] == ml(i) + 1) e_lpc = (op[i] != 3'b111);
          else e_s = 1'b1;
        end
        P_ACK:  e_s = 1'b1;
        P_EXEC: e_mc = emc[i];
        P_HALT: e_halt = 1'b1;
        P_ERR:  e_err = 1'b1;
        default: ;
      endcase
      chk("s",        i, {3'b0, s[i]},        {3'b0, e_s});
      chk("reset_pc", i, {3'b0, reset_pc[i]}, {3'b0, e_rpc});
      chk("load_pc",  i, {3'b0, load_pc[i]},  {3'b0, e_lpc});
      chk("load_ir",  i, {3'b0, load_ir[i]},  {3'b0, e_lir});
      chk("addr_sel", i, {3'b0, addr_sel[i]}, {3'b0, e_as});
      chk("mem_cmd",  i, {2'b0, mem_cmd[i]},  {2'b0, e_mc});
      chk("halted",   i, {3'b0, halted[i]},   {3'b0, e_halt});
      chk("error",    i, {3'b0, error[i]},    {3'b0, e_err});
    end
  endtask

  // Inputs change only just after a rising edge; outputs are checked on the falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    int if1_b;
    reset = 1'b0; run = 2'b00; w = 2'b11;
    op[0] = 3'd0; op[1] = 3'd0; emc[0] = 2'b10; emc[1] = 2'b10;
    @(posedge clk);
    ph[0] = P_RESET; ph[1] = P_RESET;
    age[0] = 0; age[1] = 0; waited[0] = 0; waited[1] = 0;
    #1;
    reset = 1'b1;

    // Parked in RST while run is low.
    tick(2);

    // Fetch latency and IF1 length with MEM_LAT=3; exec_mem_cmd ignored outside EXEC.
    run = 2'b11;
    lat = -1;
    if1_b = 0;
    for (int k = 0; k < 6; k++) begin
      if (s[0] === 1'b1 && lat < 0) lat = k;
      if (mem_cmd[1] === 2'b01 && addr_sel[1] === 1'b1 && load_ir[1] === 1'b0) if1_b++;
      tick(1);
    end
    chk("s_latency", 0, lat[3:0], 4'd4);
    chk("if1_cycles", 1, if1_b[3:0], 4'd3);

    // Handshake: w held high keeps s asserted in ACK.
    tick(5);
    chk("s_held_ack", 0, {3'b0, s[0]}, 4'd1);
    w = 2'b00;
    tick(3);
    chk("exec_fwd", 1, {2'b0, mem_cmd[1]}, 4'd2);
    // w returns on the 8th ACK+EXEC cycle of dut1: exit wins over timeout.
    w = 2'b11;
    tick(1);
    chk("exit_wins", 1, {3'b0, error[1]}, 4'd0);

    // Execute controller stuck busy: dut1 times out.
    w = 2'b10;
    w[1] = 1'b0;
    tick(20);
    chk("timeout_err", 1, {3'b0, error[1]}, 4'd1);
    run = 2'b00;
    tick(3);

    // HALT opcode; run is ignored once halted.
    apply_reset();
    chk("err_cleared", 1, {3'b0, error[1]}, 4'd0);
    run = 2'b11; w = 2'b11; op[0] = 3'b111; op[1] = 3'b111;
    tick(10);
    run = 2'b00;
    tick(20);
    chk("halt_sticky", 1, {3'b0, halted[1]}, 4'd1);
    apply_reset();
    chk("halt_cleared", 0, {3'b0, halted[0]}, 4'd0);

    // Randomized traffic on both configurations.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 2; i++) begin
        run[i] = ($urandom_range(0, 7) != 0);
        w[i]   = ($urandom_range(0, 9) < 4);
        op[i]  = ($urandom_range(0, 39) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
        emc[i] = 2'($urandom_range(0, 3));
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
